// File: rtl/instruction_mem_loader_pkg.sv
// Shared types and constants for the instruction memory boot loader.
package instruction_mem_loader_pkg;

  // Loader frame states: two header bytes, payload, checksum, then a terminal state.
  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Number of header bytes carrying the little-endian word count.
  localparam int unsigned HDR_BYTES      = 2;
  // Bytes assembled into one instruction word.
  localparam int unsigned BYTES_PER_WORD = 4;
  // Width of the byte-lane counter inside a word.
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
  // Width of the word count / word index.
  localparam int unsigned CNT_W          = HDR_BYTES * 8;

  // Byte address of a word index relative to the image base (32-bit wrap-around).
  function automatic logic [31:0] word_byte_addr(input logic [31:0]      base,
                                                 input logic [CNT_W-1:0] idx);
    return base + (32'(idx) << LANE_W);
  endfunction

endpackage

// File: rtl/instruction_mem_loader_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word and pulses word_valid
// for one cycle in the cycle after the fourth byte is taken.
module word_assembler
  import instruction_mem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_last_lane,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [LANE_W-1:0] r_lane;
  logic [23:0]       r_bytes;
  logic [31:0]       r_word;
  logic              r_word_valid;

  assign o_last_lane  = (r_lane == LANE_W'(BYTES_PER_WORD - 1));
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

  // Lane counter and byte shift register; the fourth byte captures the full word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lane       <= '0;
      r_bytes      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else if (i_clear) begin
      r_lane       <= '0;
      r_bytes      <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_byte_valid) begin
        r_lane <= r_lane + 1'b1;
        if (o_last_lane) begin
          r_word       <= {i_byte, r_bytes};
          r_word_valid <= 1'b1;
        end else begin
          // Newest byte enters at the top so b0 ends up in the low lane.
          r_bytes <= {i_byte, r_bytes[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/instruction_mem_loader.sv
// Boot-time instruction memory loader: parses a framed byte stream (count
// header, little-endian words, 8-bit checksum), writes each word into
// instruction memory and holds the core in reset until the image verifies.
module instruction_mem_loader
  import instruction_mem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  input  logic        i_restart,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_core_reset,
  output logic        o_done,
  output logic        o_error
);

  state_t           r_state;
  state_t           w_next_state;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_idx;
  logic [7:0]       r_sum;
  logic [31:0]      r_addr;

  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_full;
  logic             w_cnt_ok;
  logic             w_hdr_done;
  logic             w_restart;
  logic             w_last_lane;
  logic             w_word_done;
  logic             w_last_word;
  logic             w_data_byte;
  logic             w_asm_clear;
  logic [31:0]      w_word;
  logic             w_word_valid;

  assign w_accept    = i_rx_valid && o_rx_ready;
  // Header bytes shift in from the top, so after CNT_HI the count is {hi, lo}.
  assign w_cnt_full  = {i_rx_data, r_cnt[CNT_W-1:8]};
  assign w_cnt_ok    = (w_cnt_full != '0) && (32'(w_cnt_full) <= DEPTH_WORDS);
  assign w_hdr_done  = w_accept && (r_state == ST_HDR1);
  assign w_restart   = i_restart && ((r_state == ST_DONE) || (r_state == ST_ERROR));
  assign w_data_byte = w_accept && (r_state == ST_DATA);
  assign w_word_done = w_data_byte && w_last_lane;
  assign w_last_word = ((r_idx + 1'b1) == r_cnt);
  assign w_asm_clear = w_hdr_done || w_restart;

  word_assembler u_word_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_asm_clear),
    .i_byte_valid (w_data_byte),
    .i_byte       (i_rx_data),
    .o_last_lane  (w_last_lane),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_HDR0;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode from the accepted byte and restart request.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_HDR0: begin
        if (w_accept) w_next_state = ST_HDR1;
      end
      ST_HDR1: begin
        if (w_accept) w_next_state = w_cnt_ok ? ST_DATA : ST_ERROR;
      end
      ST_DATA: begin
        if (w_word_done && w_last_word) w_next_state = ST_CSUM;
      end
      ST_CSUM: begin
        if (w_accept) w_next_state = (i_rx_data == r_sum) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (i_restart) w_next_state = ST_HDR0;
      end
      default: w_next_state = ST_HDR0;
    endcase
  end

  // Status outputs decoded directly from the state register.
  always_comb begin
    o_rx_ready   = 1'b0;
    o_core_reset = 1'b1;
    o_done       = 1'b0;
    o_error      = 1'b0;
    case (r_state)
      ST_HDR0, ST_HDR1, ST_DATA, ST_CSUM: o_rx_ready = 1'b1;
      ST_DONE: begin
        o_core_reset = 1'b0;
        o_done       = 1'b1;
      end
      ST_ERROR: o_error = 1'b1;
      default: ;
    endcase
  end

  // Frame bookkeeping: word count, word index, running checksum and write address.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_sum  <= '0;
      r_addr <= BASE_ADDR;
    end else if (w_restart) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_sum <= '0;
    end else if (w_accept) begin
      case (r_state)
        ST_HDR0: r_cnt <= w_cnt_full;
        ST_HDR1: begin
          r_cnt <= w_cnt_full;
          r_idx <= '0;
          r_sum <= '0;
        end
        ST_DATA: begin
          r_sum <= r_sum + i_rx_data;
          // Address is registered alongside the assembled word so both
          // appear in the same cycle as the write strobe.
          if (w_last_lane) begin
            r_addr <= word_byte_addr(BASE_ADDR, r_idx);
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_imem_we    = w_word_valid;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = w_word;

endmodule
